mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update only on posedge clk.
REQ-002 Parameter TIMEOUT, default 15: number of ACCESS cycles without bus_ack before the access is aborted; legal range 1..15.
REQ-003 Ports SHALL be:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- memRead  input  1  load request from the EX/MEM register
- memWrite  input  1  store request from the EX/MEM register
- aluResult  input  32  byte address from the EX/MEM register
- readData2  input  32  store data from the EX/MEM register
- bus_ack  input  1  memory bus completion
- bus_rdata  input  32  memory bus read data, valid with bus_ack
- bus_req  output  1  memory bus request
- bus_we  output  1  1 = write, 0 = read
- bus_addr  output  32  word-aligned bus address
- bus_wdata  output  32  bus write data
- stall  output  1  holds all pipeline registers (combinational)
- load_data  output  32  captured load result for MEM/WB
- load_valid  output  1  one-cycle pulse: load_data valid
- bus_err  output  1  sticky error flag

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-005 In IDLE, with memRead or memWrite asserted and aluResult[1:0]==0:
- latch aluResult into bus_addr and readData2 into bus_wdata
- set bus_we = memWrite
- move to ACCESS with bus_req=1 from the next cycle
REQ-006 If memRead and memWrite are both asserted, the access SHALL be treated as a write.
REQ-007 In IDLE, with a request and aluResult[1:0]!=0:
- no bus transaction
- set bus_err
- load_data=0
- move directly to DONE
REQ-008 In ACCESS, bus_req, bus_we, bus_addr and bus_wdata SHALL be held stable until the cycle after bus_ack is sampled high.
REQ-009 In ACCESS, bus_ack=1 SHALL:
- capture bus_rdata into load_data (reads only; writes leave load_data unchanged)
- clear bus_req at the next edge
- move to DONE
REQ-010 A 4-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without bus_ack. When it reaches TIMEOUT the block SHALL:
- set bus_err
- load_data=0
- clear bus_req
- move to DONE
REQ-011 If bus_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and no error is flagged.
REQ-012 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-013 load_valid SHALL be 1 in DONE only for reads, including aborted and misaligned reads.
REQ-014 memRead and memWrite SHALL be ignored in DONE, because the same instruction is still present in EX/MEM that cycle.
REQ-015 stall SHALL be combinational and equal (IDLE and (memRead or memWrite)) or ACCESS; stall SHALL be 0 in DONE so the pipeline advances at the end of DONE.
REQ-016 bus_ack sampled in IDLE or DONE SHALL be ignored.
REQ-017 bus_err SHALL remain 1 once set, until rst.
REQ-018 Minimum latency: request seen in cycle N, bus_req high in N+1, ack in N+1, DONE in N+2; stall high in N and N+1 only.

Reset
REQ-019 While rst is sampled high, the block SHALL return to IDLE with:
- bus_req=0, bus_we=0
- bus_addr=0, bus_wdata=0
- load_data=0, load_valid=0
- bus_err=0, counter=0
REQ-020 Reset during ACCESS SHALL drop bus_req at that edge; a later bus_ack SHALL be ignored.
REQ-021 During rst, stall SHALL follow REQ-015 with state = IDLE.

Verification
REQ-022 Load with zero wait: memRead=1, aluResult=0x100, bus_ack=1 in first ACCESS cycle with bus_rdata=0xCAFEF00D -> stall high 2 cycles, then load_valid=1 and load_data=0xCAFEF00D for 1 cycle.
REQ-023 Store with 3 wait cycles: memWrite=1, aluResult=0x204, readData2=0x12345678, bus_ack on the 4th ACCESS cycle -> bus_we=1, bus_addr=0x204, bus_wdata=0x12345678 stable for 4 cycles; stall high 5 cycles; load_valid stays 0.
REQ-024 Misaligned access: memRead=1, aluResult=0x102 -> bus_req never asserted; bus_err=1; load_valid=1 with load_data=0 one cycle later; stall high 1 cycle.
REQ-025 Timeout: memRead=1, bus_ack held 0, TIMEOUT=15 -> bus_req high 15 cycles, then DONE with bus_err=1, load_data=0; bus_err remains set across later good accesses.
REQ-026 Reset mid-access: rst pulsed on the 2nd ACCESS cycle, then bus_ack=1 -> bus_req=0, state IDLE, all outputs at reset values; ack ignored; next request completes normally.
REQ-027 Back-to-back requests: load then store in consecutive instructions -> two separate bus transactions, no request dropped, store not issued during DONE of the load.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - EX/MEM data memory access controller with bus handshake, timeout and sticky error
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] aluResult,
    input  logic [31:0] readData2,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Abort fires on the edge where the counter would step onto TIMEOUT.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        bus_err_q, bus_err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_read_q, is_read_d;

    logic        req;
    logic        aligned;

    assign req     = memRead | memWrite;
    assign aligned = (aluResult[1:0] == 2'b00);

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        bus_err_d   = bus_err_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    is_read_d = ~memWrite;
                    if (aligned) begin
                        bus_addr_d  = aluResult;
                        bus_wdata_d = readData2;
                        bus_we_d    = memWrite;
                        bus_req_d   = 1'b1;
                        cnt_d       = 4'd0;
                        state_d     = ACCESS;
                    end else begin
                        bus_err_d   = 1'b1;
                        load_data_d = 32'd0;
                        state_d     = DONE;
                    end
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        load_data_d = bus_rdata;
                    end
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        bus_err_d   = 1'b1;
                        load_data_d = 32'd0;
                        bus_req_d   = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            bus_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
        end
    end

    // Under reset the state is treated as IDLE so the pipeline sees a consistent stall.
    assign stall = ((state_q == IDLE || rst) && req) || (state_q == ACCESS && !rst);

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = (state_q == DONE) && is_read_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] aluResult, readData2;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_req, bus_we, stall, load_valid, bus_err;
    logic [31:0] bus_addr, bus_wdata, load_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .aluResult (aluResult),
        .readData2 (readData2),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .stall     (stall),
        .load_data (load_data),
        .load_valid(load_valid),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0;
        aluResult = 32'd0; readData2 = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        tick(); tick();
        settle();
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_stall_noreq", {31'd0, stall}, 32'd0);
        memRead = 1'b1;
        settle();
        check("rst_stall_req", {31'd0, stall}, 32'd1);
        memRead = 1'b0;
        tick();
        rst = 1'b0;

        // Zero-wait load
        memRead = 1'b1; aluResult = 32'h100;
        settle();
        check("ld0_n_stall", {31'd0, stall}, 32'd1);
        check("ld0_n_req", {31'd0, bus_req}, 32'd0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        settle();
        check("ld0_n1_req", {31'd0, bus_req}, 32'd1);
        check("ld0_n1_we", {31'd0, bus_we}, 32'd0);
        check("ld0_n1_addr", bus_addr, 32'h100);
        check("ld0_n1_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'hDEADBEEF;
        settle();
        check("ld0_done_stall", {31'd0, stall}, 32'd0);
        check("ld0_done_req", {31'd0, bus_req}, 32'd0);
        check("ld0_done_valid", {31'd0, load_valid}, 32'd1);
        check("ld0_done_data", load_data, 32'hCAFEF00D);
        tick();
        memRead = 1'b0;
        settle();
        check("ld0_idle_valid", {31'd0, load_valid}, 32'd0);
        check("ld0_idle_stall", {31'd0, stall}, 32'd0);
        tick();

        // Store with three wait cycles
        memWrite = 1'b1; aluResult = 32'h204; readData2 = 32'h12345678;
        settle();
        check("st3_n_stall", {31'd0, stall}, 32'd1);
        tick();
        readData2 = 32'hFFFFFFFF; aluResult = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3);
            settle();
            check($sformatf("st3_a%0d_req", i), {31'd0, bus_req}, 32'd1);
            check($sformatf("st3_a%0d_we", i), {31'd0, bus_we}, 32'd1);
            check($sformatf("st3_a%0d_addr", i), bus_addr, 32'h204);
            check($sformatf("st3_a%0d_wdata", i), bus_wdata, 32'h12345678);
            check($sformatf("st3_a%0d_stall", i), {31'd0, stall}, 32'd1);
            check($sformatf("st3_a%0d_valid", i), {31'd0, load_valid}, 32'd0);
            tick();
        end
        bus_ack = 1'b0;
        settle();
        check("st3_done_stall", {31'd0, stall}, 32'd0);
        check("st3_done_req", {31'd0, bus_req}, 32'd0);
        check("st3_done_valid", {31'd0, load_valid}, 32'd0);
        check("st3_done_ldata", load_data, 32'hCAFEF00D);
        check("st3_done_err", {31'd0, bus_err}, 32'd0);
        tick();
        memWrite = 1'b0;
        tick();

        // Misaligned load
        memRead = 1'b1; aluResult = 32'h102;
        settle();
        check("mis_n_stall", {31'd0, stall}, 32'd1);
        check("mis_n_req", {31'd0, bus_req}, 32'd0);
        tick();
        settle();
        check("mis_done_req", {31'd0, bus_req}, 32'd0);
        check("mis_done_err", {31'd0, bus_err}, 32'd1);
        check("mis_done_valid", {31'd0, load_valid}, 32'd1);
        check("mis_done_data", load_data, 32'd0);
        check("mis_done_stall", {31'd0, stall}, 32'd0);
        tick();
        memRead = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst2_err_clear", {31'd0, bus_err}, 32'd0);

        // Reset during the second ACCESS cycle, then a stray ack
        memRead = 1'b1; aluResult = 32'h300;
        tick();
        settle();
        check("rma_a1_req", {31'd0, bus_req}, 32'd1);
        tick();
        rst = 1'b1;
        settle();
        check("rma_rst_stall", {31'd0, stall}, 32'd1);
        tick();
        rst = 1'b0; memRead = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
        settle();
        check("rma_req", {31'd0, bus_req}, 32'd0);
        check("rma_stall", {31'd0, stall}, 32'd0);
        check("rma_addr", bus_addr, 32'd0);
        check("rma_ldata", load_data, 32'd0);
        check("rma_valid", {31'd0, load_valid}, 32'd0);
        tick();
        bus_ack = 1'b0;
        settle();
        check("rma_ack_ign_valid", {31'd0, load_valid}, 32'd0);
        check("rma_ack_ign_ldata", load_data, 32'd0);
        memRead = 1'b1; aluResult = 32'h400;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h55AA33CC;
        settle();
        check("rma_next_addr", bus_addr, 32'h400);
        tick();
        bus_ack = 1'b0;
        settle();
        check("rma_next_valid", {31'd0, load_valid}, 32'd1);
        check("rma_next_data", load_data, 32'h55AA33CC);
        check("rma_next_err", {31'd0, bus_err}, 32'd0);
        tick();
        memRead = 1'b0;
        tick();

        // Timeout: bus_req for exactly 15 cycles
        memRead = 1'b1; aluResult = 32'h500;
        tick();
        for (int i = 0; i < 15; i++) begin
            settle();
            check($sformatf("to_c%0d_req", i), {31'd0, bus_req}, 32'd1);
            check($sformatf("to_c%0d_err", i), {31'd0, bus_err}, 32'd0);
            tick();
        end
        settle();
        check("to_done_req", {31'd0, bus_req}, 32'd0);
        check("to_done_err", {31'd0, bus_err}, 32'd1);
        check("to_done_valid", {31'd0, load_valid}, 32'd1);
        check("to_done_data", load_data, 32'd0);
        check("to_done_stall", {31'd0, stall}, 32'd0);
        tick();
        memRead = 1'b0;
        tick();

        // Back-to-back load then store (read+write together counts as write)
        memRead = 1'b1; aluResult = 32'h600;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        tick();
        bus_ack = 1'b0;
        settle();
        check("b2b_ld_valid", {31'd0, load_valid}, 32'd1);
        check("b2b_ld_data", load_data, 32'h11111111);
        check("b2b_ld_done_req", {31'd0, bus_req}, 32'd0);
        tick();
        memRead = 1'b1; memWrite = 1'b1; aluResult = 32'h604; readData2 = 32'h22222222;
        settle();
        check("b2b_st_n_stall", {31'd0, stall}, 32'd1);
        check("b2b_st_n_req", {31'd0, bus_req}, 32'd0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h99999999;
        settle();
        check("b2b_st_req", {31'd0, bus_req}, 32'd1);
        check("b2b_st_we", {31'd0, bus_we}, 32'd1);
        check("b2b_st_addr", bus_addr, 32'h604);
        check("b2b_st_wdata", bus_wdata, 32'h22222222);
        tick();
        bus_ack = 1'b0;
        settle();
        check("b2b_st_valid", {31'd0, load_valid}, 32'd0);
        check("b2b_st_ldata", load_data, 32'h11111111);
        check("b2b_err_sticky", {31'd0, bus_err}, 32'd1);
        tick();
        memRead = 1'b0; memWrite = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
